// File: rtl/iob_reg_arbiter.sv
// Round-robin write arbiter sharing one register between N_REQ requesters,
// with an optional owner lock bounded by a hold timeout.
module iob_reg_arbiter #(
  parameter int unsigned        N_REQ    = 4,
  parameter int unsigned        DATA_W   = 32,
  parameter logic [DATA_W-1:0]  RST_VAL  = '0,
  parameter int unsigned        MAX_HOLD = 16,
  localparam int unsigned       ID_W     = $clog2(N_REQ)
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic                      cke_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ-1:0]          lock_i,
  input  logic [N_REQ*DATA_W-1:0]   data_i,
  output logic [N_REQ-1:0]          ack_o,
  output logic [DATA_W-1:0]         data_o,
  output logic                      upd_o,
  output logic [ID_W-1:0]           grant_id_o,
  output logic                      busy_o
);

  localparam int unsigned CNT_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t             state_q, state_nxt;
  logic [ID_W-1:0]    owner_q, owner_nxt;
  logic [ID_W-1:0]    ptr_q, ptr_nxt;
  logic [CNT_W-1:0]   cnt_q, cnt_nxt;
  logic [DATA_W-1:0]  data_nxt;
  logic               upd_nxt;
  logic [ID_W-1:0]    gid_nxt;
  logic               busy_nxt;
  logic [N_REQ-1:0]   ack_c;
  logic [ID_W-1:0]    winner_c;
  logic               any_req_c;
  logic [DATA_W-1:0]  data_a [N_REQ];

  for (genvar g = 0; g < int'(N_REQ); g++) begin : g_unpack
    assign data_a[g] = data_i[g*DATA_W +: DATA_W];
  end

  // Circular scan from ptr+1; descending loop leaves the first hit in winner_c.
  always_comb begin
    int idx;
    idx       = 0;
    winner_c  = '0;
    any_req_c = |req_i;
    for (int i = int'(N_REQ); i >= 1; i--) begin
      idx = (int'(ptr_q) + i) % int'(N_REQ);
      if (req_i[ID_W'(idx)]) winner_c = ID_W'(idx);
    end
  end

  always_comb begin
    state_nxt = state_q;
    owner_nxt = owner_q;
    ptr_nxt   = ptr_q;
    cnt_nxt   = cnt_q;
    data_nxt  = data_o;
    upd_nxt   = 1'b0;
    gid_nxt   = grant_id_o;
    ack_c     = '0;
    if (cke_i && arst_n_i) begin
      unique case (state_q)
        IDLE: begin
          if (any_req_c) begin
            ack_c    = N_REQ'(1) << winner_c;
            data_nxt = data_a[winner_c];
            upd_nxt  = 1'b1;
            gid_nxt  = winner_c;
            ptr_nxt  = winner_c;
            if (lock_i[winner_c]) begin
              state_nxt = OWNED;
              owner_nxt = winner_c;
              cnt_nxt   = CNT_W'(1);
            end
          end
        end
        OWNED: begin
          ack_c[owner_q] = req_i[owner_q];
          if (req_i[owner_q]) begin
            data_nxt = data_a[owner_q];
            upd_nxt  = 1'b1;
            gid_nxt  = owner_q;
          end
          // Release on lock drop or timeout; the cycle's write is still taken.
          if (!lock_i[owner_q] || ((MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD)))) begin
            state_nxt = IDLE;
            ptr_nxt   = owner_q;
            cnt_nxt   = '0;
          end else if (cnt_q != {CNT_W{1'b1}}) begin
            cnt_nxt = cnt_q + CNT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
    busy_nxt = (state_nxt == OWNED);
  end

  assign ack_o = ack_c;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      ptr_q      <= ID_W'(N_REQ - 1);
      cnt_q      <= '0;
      data_o     <= RST_VAL;
      upd_o      <= 1'b0;
      grant_id_o <= '0;
      busy_o     <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      owner_q    <= owner_nxt;
      ptr_q      <= ptr_nxt;
      cnt_q      <= cnt_nxt;
      data_o     <= data_nxt;
      upd_o      <= upd_nxt;
      grant_id_o <= gid_nxt;
      busy_o     <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_iob_reg_arbiter.sv
// Bench for iob_reg_arbiter: two instances (hold limit 16 and 4) against a
// behavioural model, plus directed literal expectations.
module tb_iob_reg_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 32;
  localparam logic [DW-1:0] RST = 32'hCAFE_0000;

  logic               clk = 1'b0;
  logic               arst_n;
  logic               cke;
  logic [N-1:0]       req;
  logic [N-1:0]       lock;
  logic [N*DW-1:0]    din;
  logic [1:0][N-1:0]  ack_w;
  logic [1:0][DW-1:0] data_w;
  logic [1:0]         upd_w;
  logic [1:0][1:0]    gid_w;
  logic [1:0]         busy_w;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  iob_reg_arbiter #(.N_REQ(N), .DATA_W(DW), .RST_VAL(RST), .MAX_HOLD(16)) dut (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .req_i(req), .lock_i(lock),
    .data_i(din), .ack_o(ack_w[0]), .data_o(data_w[0]), .upd_o(upd_w[0]),
    .grant_id_o(gid_w[0]), .busy_o(busy_w[0]));

  iob_reg_arbiter #(.N_REQ(N), .DATA_W(DW), .RST_VAL(RST), .MAX_HOLD(4)) dut_h (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke), .req_i(req), .lock_i(lock),
    .data_i(din), .ack_o(ack_w[1]), .data_o(data_w[1]), .upd_o(upd_w[1]),
    .grant_id_o(gid_w[1]), .busy_o(busy_w[1]));

  // Model state per instance: register contents plus ownership bookkeeping.
  logic [DW-1:0] m_data [2];
  logic          m_upd  [2];
  int            m_gid  [2];
  bit            m_own  [2];
  int            m_owner[2];
  int            m_held [2];
  int            m_ptr  [2];

  function automatic int hold_lim(int u);
    return (u == 0) ? 16 : 4;
  endfunction

  function automatic logic [N-1:0] exp_ack(int u);
    if (!arst_n || !cke) return '0;
    if (m_own[u]) return req[m_owner[u]] ? (N'(1) << m_owner[u]) : '0;
    for (int i = 1; i <= N; i++) begin
      int k;
      k = (m_ptr[u] + i) % N;
      if (req[k]) return N'(1) << k;
    end
    return '0;
  endfunction

  always @(posedge clk or negedge arst_n) begin
    for (int u = 0; u < 2; u++) begin
      if (!arst_n) begin
        m_data[u] = RST; m_upd[u] = 1'b0; m_gid[u] = 0;
        m_own[u] = 1'b0; m_owner[u] = 0; m_held[u] = 0; m_ptr[u] = N - 1;
      end else if (!cke) begin
        m_upd[u] = 1'b0;
      end else begin
        logic [N-1:0] a;
        int t;
        a = exp_ack(u);
        t = -1;
        m_upd[u] = 1'b0;
        for (int k = 0; k < N; k++)
          if (a[k] && req[k]) t = k;
        if (t >= 0) begin
          m_data[u] = din[t*DW +: DW];
          m_upd[u]  = 1'b1;
          m_gid[u]  = t;
        end
        if (m_own[u]) begin
          m_held[u]++;
          if (!lock[m_owner[u]] || (hold_lim(u) != 0 && m_held[u] >= hold_lim(u))) begin
            m_own[u] = 1'b0;
            m_ptr[u] = m_owner[u];
          end
        end else if (t >= 0) begin
          m_ptr[u] = t;
          if (lock[t]) begin
            m_own[u] = 1'b1; m_owner[u] = t; m_held[u] = 0;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Every cycle, away from the active edge, compare both instances to the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int u = 0; u < 2; u++) begin
        check($sformatf("m%0d_ack", u),  64'(ack_w[u]),  64'(exp_ack(u)));
        check($sformatf("m%0d_data", u), 64'(data_w[u]), 64'(m_data[u]));
        check($sformatf("m%0d_upd", u),  64'(upd_w[u]),  64'(m_upd[u]));
        check($sformatf("m%0d_gid", u),  64'(gid_w[u]),  64'(m_gid[u]));
        check($sformatf("m%0d_busy", u), 64'(busy_w[u]), 64'(m_own[u]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_data(input logic [DW-1:0] base);
    for (int k = 0; k < N; k++) din[k*DW +: DW] = base + DW'(k);
  endtask

  logic [N-1:0] to_ack [7];
  int           to_win [7];
  bit           to_busy[7];

  initial begin
    to_ack  = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010};
    to_win  = '{1, 1, 1, 1, 1, 0, 1};
    to_busy = '{1, 1, 1, 1, 0, 0, 1};

    arst_n = 1'b0; cke = 1'b1; req = 4'b1111; lock = '0; set_data(32'h100);
    repeat (2) tick();
    chk_en = 1;
    #1;
    check("rst_data", 64'(data_w[0]), 64'(RST));
    check("rst_upd",  64'(upd_w[0]),  64'd0);
    check("rst_busy", 64'(busy_w[0]), 64'd0);
    check("rst_ack",  64'(ack_w[0]),  64'd0);
    arst_n = 1'b1;
    #1;
    check("first_ack", 64'(ack_w[0]), 64'b0001);

    // Round robin with all requesters active.
    for (int c = 0; c < 8; c++) begin
      set_data(32'h100 + DW'(16 * c));
      #1 check($sformatf("rr_ack%0d", c), 64'(ack_w[0]), 64'(4'b0001 << (c % 4)));
      tick();
      check($sformatf("rr_data%0d", c), 64'(data_w[0]), 64'(32'h100 + 16 * c + c % 4));
      check($sformatf("rr_gid%0d", c),  64'(gid_w[0]),  64'(c % 4));
      check($sformatf("rr_upd%0d", c),  64'(upd_w[0]),  64'd1);
    end
    req = '0;
    tick();
    check("idle_upd", 64'(upd_w[0]), 64'd0);

    // Lock burst by requester 2 while requester 0 waits.
    req = 4'b0100; lock = 4'b0100; set_data(32'h2000);
    #1 check("lk_ack0", 64'(ack_w[0]), 64'b0100);
    tick();
    check("lk_busy0", 64'(busy_w[0]), 64'd1);
    check("lk_data0", 64'(data_w[0]), 64'h2002);
    for (int n = 1; n <= 5; n++) begin
      req = 4'b0101; set_data(32'h2000 + DW'(16 * n));
      #1 check($sformatf("lk_ack%0d", n), 64'(ack_w[0]), 64'b0100);
      tick();
      check($sformatf("lk_data%0d", n), 64'(data_w[0]), 64'(32'h2002 + 16 * n));
      check($sformatf("lk_busy%0d", n), 64'(busy_w[0]), 64'd1);
    end
    lock = '0; set_data(32'h2100);
    #1 check("lk_fin_ack", 64'(ack_w[0]), 64'b0100);
    tick();
    check("lk_fin_data", 64'(data_w[0]), 64'h2102);
    check("lk_fin_busy", 64'(busy_w[0]), 64'd0);
    req = 4'b0001; set_data(32'h2200);
    #1 check("lk_next_ack", 64'(ack_w[0]), 64'b0001);
    tick();
    check("lk_next_data", 64'(data_w[0]), 64'h2200);
    req = '0;
    tick();

    // Hold timeout on the MAX_HOLD=4 instance.
    req = 4'b0011; lock = 4'b0010;
    for (int t = 0; t < 7; t++) begin
      set_data(32'h4000 + DW'(16 * t));
      #1 check($sformatf("to_ack%0d", t), 64'(ack_w[1]), 64'(to_ack[t]));
      tick();
      check($sformatf("to_busy%0d", t), 64'(busy_w[1]), 64'(to_busy[t]));
      check($sformatf("to_data%0d", t), 64'(data_w[1]), 64'(32'h4000 + 16 * t + to_win[t]));
    end
    check("to_main_busy", 64'(busy_w[0]), 64'd1);
    req = '0; lock = '0;
    tick();

    // Clock enable freeze in the middle of a lock burst by requester 3.
    req = 4'b1001; lock = 4'b1000; set_data(32'h3000);
    #1 check("ck_ack0", 64'(ack_w[0]), 64'b1000);
    tick();
    set_data(32'h3010);
    tick();
    check("ck_data1", 64'(data_w[0]), 64'h3013);
    cke = 1'b0; set_data(32'h3020);
    #1 check("ck_ack_off", 64'(ack_w[0]), 64'd0);
    check("ck_ack_off_h", 64'(ack_w[1]), 64'd0);
    for (int f = 0; f < 3; f++) begin
      tick();
      check($sformatf("ck_frz_data%0d", f), 64'(data_w[1]), 64'h3013);
      check($sformatf("ck_frz_upd%0d", f),  64'(upd_w[1]),  64'd0);
      check($sformatf("ck_frz_busy%0d", f), 64'(busy_w[1]), 64'd1);
    end
    cke = 1'b1; set_data(32'h3050);
    #1 check("ck_resume_ack", 64'(ack_w[1]), 64'b1000);
    tick();
    check("ck_resume_data", 64'(data_w[1]), 64'h3053);
    check("ck_resume_busy", 64'(busy_w[1]), 64'd1);
    set_data(32'h3060);
    tick();
    check("ck_hold3_busy", 64'(busy_w[1]), 64'd1);
    set_data(32'h3070);
    tick();
    check("ck_hold4_busy", 64'(busy_w[1]), 64'd0);
    check("ck_hold4_data", 64'(data_w[1]), 64'h3073);
    check("ck_main_busy",  64'(busy_w[0]), 64'd1);

    // Reset during ownership.
    req = 4'b1111; lock = '0; arst_n = 1'b0;
    #1;
    check("mr_data", 64'(data_w[0]), 64'(RST));
    check("mr_busy", 64'(busy_w[0]), 64'd0);
    check("mr_ack",  64'(ack_w[0]),  64'd0);
    tick();
    arst_n = 1'b1;
    #1 check("mr_rel_ack", 64'(ack_w[0]), 64'b0001);
    tick();
    check("mr_rel_data", 64'(data_w[0]), 64'h3070);
    check("mr_rel_gid",  64'(gid_w[0]),  64'd0);
    req = '0;
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
